// File: rtl/mem_map_pkg.sv
// Shared MMIO map for the data-memory responder.
// Holds the MMIO window base, the byte offsets of each register in the
// window, and the bit positions of the TCTRL and FIFO_STAT fields.
package mem_map_pkg;

  localparam logic [15:0] MMIO_BASE = 16'hFFFF;

  localparam logic [7:0] OFF_CYCLE     = 8'h00;
  localparam logic [7:0] OFF_TCMP      = 8'h04;
  localparam logic [7:0] OFF_TCTRL     = 8'h08;
  localparam logic [7:0] OFF_TCOUNT    = 8'h0C;
  localparam logic [7:0] OFF_FIFO_DATA = 8'h10;
  localparam logic [7:0] OFF_FIFO_STAT = 8'h14;

  localparam int unsigned TCTRL_EN_BIT   = 0;
  localparam int unsigned TCTRL_PEND_BIT = 1;

  localparam int unsigned STAT_FULL_BIT  = 0;
  localparam int unsigned STAT_EMPTY_BIT = 1;
  localparam int unsigned STAT_OVF_BIT   = 2;
  localparam int unsigned STAT_CNT_LSB   = 8;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count.
// Ports:
//   clk, rst_ni   : clock, asynchronous active-low reset
//   push_i        : push request (dropped when full unless pop_i pops this cycle)
//   push_data_i   : word to push
//   pop_i         : pop request (ignored when empty)
//   head_o        : current head entry (undefined when empty)
//   full_o        : count == DEPTH
//   empty_o       : count == 0
//   count_o       : current occupancy
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_en, push_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees a slot in the same edge, so a push to a full FIFO is
  // still accepted when it coincides with a pop.
  assign pop_en  = pop_i && !empty_o;
  assign push_en = push_i && (!full_o || pop_en);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle MIPS core.
// Low address space is word RAM (aliased by address wrap); addr[31:16] ==
// 16'hFFFF selects an MMIO window with a cycle counter, compare timer and
// an output FIFO drained through a valid/ready stream.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   memwrite          : store strobe from the core
//   addr, writedata   : byte address and store data
//   readdata          : combinational load data (pre-edge state)
//   out_data/valid    : FIFO head / non-empty
//   out_ready         : downstream accept
//   timer_irq         : timer pending flag
module data_mem_responder
  import mem_map_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 64,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        timer_irq
);

  localparam int unsigned RAW = $clog2(RAM_WORDS);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;

  logic [31:0] ram_q [RAM_WORDS];
  logic [RAW-1:0] ram_idx;
  logic        is_mmio;
  logic [7:0]  off;
  logic        we_tcmp, we_tctrl, we_tcount, we_fdata, we_fstat;

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic [31:0] tcount_q, tcount_d;
  logic        en_q, en_d;
  logic        pend_q, pend_d;
  logic        ovf_q, ovf_d;
  logic        timer_match;

  logic          fifo_full, fifo_empty, fifo_pop, fifo_drop;
  logic [CW-1:0] fifo_count;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[15:8], addr[1:0]};

  assign is_mmio = (addr[31:16] == MMIO_BASE);
  assign off     = {addr[7:2], 2'b00};
  assign ram_idx = addr[RAW+1:2];

  assign we_tcmp   = memwrite && is_mmio && (off == OFF_TCMP);
  assign we_tctrl  = memwrite && is_mmio && (off == OFF_TCTRL);
  assign we_tcount = memwrite && is_mmio && (off == OFF_TCOUNT);
  assign we_fdata  = memwrite && is_mmio && (off == OFF_FIFO_DATA);
  assign we_fstat  = memwrite && is_mmio && (off == OFF_FIFO_STAT);

  assign timer_match = en_q && (tcount_q == tcmp_q);
  assign timer_irq   = pend_q;

  assign out_valid = !fifo_empty;
  assign fifo_pop  = out_valid && out_ready;
  assign fifo_drop = we_fdata && fifo_full && !fifo_pop;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_ni      (rst),
    .push_i      (we_fdata),
    .push_data_i (writedata),
    .pop_i       (fifo_pop),
    .head_o      (out_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Set events are applied after their write-1-clear so that set wins.
  always_comb begin
    cycle_d  = cycle_q + 32'd1;
    tcmp_d   = tcmp_q;
    tcount_d = tcount_q;
    en_d     = en_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    if (we_tcmp) tcmp_d = writedata;
    if (we_tctrl) begin
      en_d = writedata[TCTRL_EN_BIT];
      if (writedata[TCTRL_PEND_BIT]) pend_d = 1'b0;
    end
    if (timer_match) pend_d = 1'b1;
    if (we_tcount)        tcount_d = writedata;
    else if (timer_match) tcount_d = '0;
    else if (en_q)        tcount_d = tcount_q + 32'd1;
    if (we_fstat && writedata[STAT_OVF_BIT]) ovf_d = 1'b0;
    if (fifo_drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q  <= '0;
      tcmp_q   <= '0;
      tcount_q <= '0;
      en_q     <= 1'b0;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      cycle_q  <= cycle_d;
      tcmp_q   <= tcmp_d;
      tcount_q <= tcount_d;
      en_q     <= en_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (memwrite && !is_mmio) ram_q[ram_idx] <= writedata;
  end

  always_comb begin
    readdata = '0;
    if (is_mmio) begin
      case (off)
        OFF_CYCLE:  readdata = cycle_q;
        OFF_TCMP:   readdata = tcmp_q;
        OFF_TCTRL: begin
          readdata[TCTRL_EN_BIT]   = en_q;
          readdata[TCTRL_PEND_BIT] = pend_q;
        end
        OFF_TCOUNT: readdata = tcount_q;
        OFF_FIFO_STAT: begin
          readdata[STAT_FULL_BIT]                  = fifo_full;
          readdata[STAT_EMPTY_BIT]                 = fifo_empty;
          readdata[STAT_OVF_BIT]                   = ovf_q;
          readdata[STAT_CNT_LSB +: 8]              = 8'(fifo_count);
        end
        default:    readdata = '0;
      endcase
    end else begin
      readdata = ram_q[ram_idx];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam logic [31:0] A_CYC  = 32'hFFFF0000;
  localparam logic [31:0] A_TCMP = 32'hFFFF0004;
  localparam logic [31:0] A_TCTL = 32'hFFFF0008;
  localparam logic [31:0] A_TCNT = 32'hFFFF000C;
  localparam logic [31:0] A_FD   = 32'hFFFF0010;
  localparam logic [31:0] A_FS   = 32'hFFFF0014;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] addr = A_CYC;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        timer_irq;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(
    .RAM_WORDS  (64),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_cyc = '0, m_tcmp = '0, m_tcnt = '0;
  logic        m_en = 1'b0, m_pend = 1'b0, m_ovf = 1'b0;
  logic [31:0] m_q [$];
  logic [31:0] m_ram [int];

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    if (a[31:16] == 16'hFFFF) begin
      case (a[7:2])
        6'd0: r = m_cyc;
        6'd1: r = m_tcmp;
        6'd2: r = {30'd0, m_pend, m_en};
        6'd3: r = m_tcnt;
        6'd5: r = {16'd0, 8'(m_q.size()), 5'd0, m_ovf,
                   (m_q.size() == 0), (m_q.size() == DEPTH)};
        default: r = '0;
      endcase
    end else if (m_ram.exists(int'((a >> 2) & 32'd63))) begin
      r = m_ram[int'((a >> 2) & 32'd63)];
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_cyc = '0; m_tcmp = '0; m_tcnt = '0;
      m_en = 1'b0; m_pend = 1'b0; m_ovf = 1'b0;
      m_q.delete();
      m_ram.delete();
    end else begin
      logic mm, match, pop, push;
      logic [5:0] o;
      mm    = (addr[31:16] == 16'hFFFF);
      o     = addr[7:2];
      match = m_en && (m_tcnt == m_tcmp);
      pop   = (m_q.size() != 0) && out_ready;
      push  = memwrite && mm && (o == 6'd4);
      m_cyc = m_cyc + 1;
      if (memwrite && mm && o == 6'd3) m_tcnt = writedata;
      else if (match)                  m_tcnt = 0;
      else if (m_en)                   m_tcnt = m_tcnt + 1;
      if (memwrite && mm && o == 6'd1) m_tcmp = writedata;
      if (memwrite && mm && o == 6'd2) begin
        if (writedata[1]) m_pend = 1'b0;
        m_en = writedata[0];
      end
      if (match) m_pend = 1'b1;
      if (memwrite && mm && o == 6'd5 && writedata[2]) m_ovf = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(writedata);
        else m_ovf = 1'b1;
      end
      if (memwrite && !mm) m_ram[int'((addr >> 2) & 32'd63)] = writedata;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (addr[31:16] == 16'hFFFF || m_ram.exists(int'((addr >> 2) & 32'd63)))
      chk("model_readdata", readdata, model_rd(addr));
    chk("model_out_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) chk("model_out_data", out_data, m_q[0]);
    chk("model_timer_irq", {31'd0, timer_irq}, {31'd0, m_pend});
  end

  // ---------------- directed stimulus ----------------
  task automatic op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                    input logic rdy, output logic [31:0] rd);
    @(posedge clk);
    #2;
    memwrite  = we;
    addr      = a;
    writedata = wd;
    out_ready = rdy;
    @(negedge clk);
    rd = readdata;
  endtask

  initial begin
    logic [31:0] rd;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("cycle_first", readdata, 32'd0);
    op(1, A_CYC, 32'hDEADBEEF, 0, rd); chk("cycle_one", rd, 32'd1);
    op(0, A_CYC, 0, 0, rd);            chk("cycle_wr_ignored", rd, 32'd2);

    // RAM
    op(1, 32'h10, 32'h12345678, 0, rd);
    op(1, 32'h10, 32'hAAAA5555, 0, rd); chk("ram_read_old", rd, 32'h12345678);
    op(0, 32'h10, 0, 0, rd);            chk("ram_read_new", rd, 32'hAAAA5555);
    op(0, 32'h110, 0, 0, rd);           chk("ram_alias", rd, 32'hAAAA5555);
    op(1, 32'hFFFF0040, 32'h5, 0, rd);  chk("unmapped_rd", rd, 32'd0);
    op(0, 32'hFFFF0040, 0, 0, rd);      chk("unmapped_wr", rd, 32'd0);

    // Timer
    op(1, A_TCMP, 32'd3, 0, rd);
    op(1, A_TCNT, 32'd0, 0, rd);
    op(1, A_TCTL, 32'd1, 0, rd);
    for (int i = 0; i < 4; i++) begin
      op(0, A_TCNT, 0, 0, rd);
      chk("tcount_run", rd, 32'(i));
      chk("irq_low", {31'd0, timer_irq}, 32'd0);
    end
    op(0, A_TCNT, 0, 0, rd);
    chk("tcount_reload", rd, 32'd0);
    chk("irq_rise", {31'd0, timer_irq}, 32'd1);
    op(1, A_TCTL, 32'd3, 0, rd);
    op(0, A_TCTL, 0, 0, rd);
    chk("tctrl_cleared", rd, 32'd1);
    chk("irq_cleared", {31'd0, timer_irq}, 32'd0);
    op(1, A_TCTL, 32'd3, 0, rd);        // issued in the match cycle
    chk("tcount_at_match", dut.tcount_q, 32'd3);
    op(0, A_TCTL, 0, 0, rd);
    chk("set_wins", rd, 32'd3);
    chk("irq_set_wins", {31'd0, timer_irq}, 32'd1);
    op(1, A_TCTL, 32'd0, 0, rd);        // stop timer, keep pend

    // FIFO fill and overflow
    for (int i = 1; i <= 9; i++) op(1, A_FD, 32'(i), 0, rd);
    op(0, A_FS, 0, 0, rd);
    chk("stat_full_ovf", rd, 32'h0000_0805);
    for (int i = 1; i <= 8; i++) begin
      op(0, A_FS, 0, 1, rd);
      chk("drain_valid", {31'd0, out_valid}, 32'd1);
      chk("drain_data", out_data, 32'(i));
    end
    op(0, A_FS, 0, 0, rd);
    chk("drained_valid", {31'd0, out_valid}, 32'd0);
    chk("stat_empty_ovf", rd, 32'h0000_0006);
    op(1, A_FS, 32'd4, 0, rd);
    op(0, A_FS, 0, 0, rd);
    chk("stat_ovf_clear", rd, 32'h0000_0002);

    // FIFO full with simultaneous pop
    for (int i = 1; i <= 8; i++) op(1, A_FD, 32'(i), 0, rd);
    op(1, A_FD, 32'd9, 1, rd);
    chk("fullpop_head", out_data, 32'd1);
    op(0, A_FS, 0, 0, rd);
    chk("stat_fullpop", rd, 32'h0000_0801);
    for (int i = 2; i <= 9; i++) begin
      op(0, A_FS, 0, 1, rd);
      chk("fullpop_drain", out_data, 32'(i));
    end
    op(0, A_FS, 0, 0, rd);
    chk("stat_empty2", rd, 32'h0000_0002);

    // Push and pop together on an empty FIFO
    op(1, A_FD, 32'h77, 1, rd);
    chk("emptypush_valid0", {31'd0, out_valid}, 32'd0);
    op(0, A_FS, 0, 0, rd);
    chk("emptypush_stat", rd, 32'h0000_0100);
    chk("emptypush_data", out_data, 32'h77);

    // Reset mid-operation
    op(1, A_FD, 32'hA, 0, rd);
    op(1, A_FD, 32'hB, 0, rd);
    op(1, A_TCNT, 32'd5, 0, rd);
    op(0, A_TCNT, 0, 0, rd);
    chk("pre_rst_tcount", rd, 32'd5);
    chk("pre_rst_irq", {31'd0, timer_irq}, 32'd1);
    chk("pre_rst_stat", dut.fifo_count, 32'd3);
    @(posedge clk);
    #2;
    rst = 1'b0; memwrite = 1'b0; addr = A_CYC;
    #1;
    chk("rst_cycle", readdata, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_irq", {31'd0, timer_irq}, 32'd0);
    addr = A_TCNT;
    #1;
    chk("rst_tcount", readdata, 32'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    addr = A_FS;
    @(negedge clk);
    chk("post_rst_stat", readdata, 32'h0000_0002);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
